// File: rtl/nova_ext_ram_arbiter_if.sv
// nova_ext_ram_arbiter_if: requester and RAM pin bundle for the frame RAM arbiter
interface nova_ext_ram_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic                  stop;
    logic [2:0]            req;
    logic [2:0]            wr;
    logic [3*ADDR_W-1:0]   addr;
    logic [3*DATA_W-1:0]   wdata;
    logic [2:0]            gnt;
    logic [2:0]            rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  ram_cs_n;
    logic                  ram_wr;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_din;
    logic [DATA_W-1:0]     ram_dout;
    logic [1:0]            owner;
    logic                  busy;
    modport master (
        output stop, req, wr, addr, wdata, ram_dout,
        input  gnt, rvalid, rdata, ram_cs_n, ram_wr, ram_addr, ram_din, owner, busy
    );
    modport slave (
        input  stop, req, wr, addr, wdata, ram_dout,
        output gnt, rvalid, rdata, ram_cs_n, ram_wr, ram_addr, ram_din, owner, busy
    );
endinterface

// File: rtl/nova_ext_ram_arbiter.sv
// nova_ext_ram_arbiter: round-robin burst-locked arbiter for one frame RAM (NOVA_ARB_WR_PRIORITY_EN selects fixed 0>1>2 priority)
module nova_ext_ram_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4,
    parameter int RD_LAT    = 1
) (
    input logic clk,
    input logic reset_n,
    nova_ext_ram_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic [1:0] owner_q, owner_nx, last_q, last_nx, own, pick;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic own_req, acc;
    logic [RD_LAT:0] tag_v;
    logic [RD_LAT:0][1:0] tag_o;
    assign own     = (owner_q == 2'd3) ? 2'd0 : owner_q;
    assign own_req = bus.req[own];
    assign acc     = (state == BURST) & own_req & ~bus.stop;
    assign bus.gnt = acc ? 3'b001 << own : 3'b000;
    assign bus.owner = owner_q;
    assign bus.busy  = (state != IDLE) | (|tag_v);
`ifdef NOVA_ARB_WR_PRIORITY_EN
    assign pick = bus.req[0] ? 2'd0 : bus.req[1] ? 2'd1 : 2'd2;
`else
    logic [1:0] s0, s1, s2;
    assign s0   = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    assign s1   = (s0 == 2'd2) ? 2'd0 : s0 + 2'd1;
    assign s2   = (s1 == 2'd2) ? 2'd0 : s1 + 2'd1;
    assign pick = bus.req[s0] ? s0 : bus.req[s1] ? s1 : s2;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            owner_q <= 2'd3;
            last_q  <= 2'd2;
            cnt_q   <= '0;
        end else begin
            state   <= state_nx;
            owner_q <= owner_nx;
            last_q  <= last_nx;
            cnt_q   <= cnt_nx;
        end
    end
    // stop freezes the burst entirely, so release is only evaluated when stop is low
    always_comb begin
        state_nx = state;
        owner_nx = owner_q;
        last_nx  = last_q;
        cnt_nx   = cnt_q;
        if (state == IDLE) begin
            if (|bus.req && !bus.stop) begin
                state_nx = BURST;
                owner_nx = pick;
            end
        end else if (!bus.stop) begin
            cnt_nx = acc ? cnt_q + 1'b1 : cnt_q;
            if (!own_req || cnt_q == CNT_W'(BURST_LEN - 1)) begin
                state_nx = IDLE;
                owner_nx = 2'd3;
                last_nx  = owner_q;
                cnt_nx   = '0;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.ram_cs_n <= 1'b1;
            bus.ram_wr   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_din  <= '0;
            tag_v        <= '0;
            tag_o        <= '0;
            bus.rvalid   <= 3'b000;
            bus.rdata    <= '0;
        end else begin
            bus.ram_cs_n <= ~acc;
            bus.ram_wr   <= acc & bus.wr[own];
            if (acc) begin
                bus.ram_addr <= bus.addr[own*ADDR_W +: ADDR_W];
                bus.ram_din  <= bus.wdata[own*DATA_W +: DATA_W];
            end
            tag_v      <= {tag_v[RD_LAT-1:0], acc & ~bus.wr[own]};
            tag_o      <= {tag_o[RD_LAT-1:0], own};
            bus.rvalid <= tag_v[RD_LAT] ? 3'b001 << tag_o[RD_LAT] : 3'b000;
            if (tag_v[RD_LAT]) bus.rdata <= bus.ram_dout;
        end
    end
endmodule

// File: tb/tb_nova_ext_ram_arbiter.sv
// tb_nova_ext_ram_arbiter: directed and random stimulus checked against a transaction-level model
module tb_nova_ext_ram_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int RL = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nova_ext_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    nova_ext_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .RD_LAT(RL)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    // RAM device: synchronous read, data valid one cycle after the select cycle
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk)
        if (!bus.ram_cs_n) begin
            if (bus.ram_wr) ram[bus.ram_addr] <= bus.ram_din;
            else bus.ram_dout <= ram[bus.ram_addr];
        end

    int checks = 0;
    int failures = 0;
    int cnum = 0;
    int m_owner, m_last, m_beats;
    bit m_burst;
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic e_cs_n, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rdata;
    typedef struct { int due; int own; logic [DW-1:0] data; } rd_t;
    rd_t rq[$];
`ifdef NOVA_ARB_WR_PRIORITY_EN
    int exp_own[4] = '{0, 0, 0, 0};
`else
    int exp_own[4] = '{0, 1, 2, 0};
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r);
`ifdef NOVA_ARB_WR_PRIORITY_EN
        for (int i = 0; i < 3; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= 3; k++) if (r[(m_last + k) % 3]) return (m_last + k) % 3;
`endif
        return 3;
    endfunction

    task automatic model_reset();
        m_owner = 3; m_last = 2; m_beats = 0; m_burst = 0;
        e_cs_n = 1; e_wr = 0; e_addr = '0; e_din = '0; e_rdata = '0;
        rq.delete();
    endtask

    task automatic check_all();
        logic [2:0] eg = 3'b000;
        logic [2:0] ev = 3'b000;
        if (m_burst && bus.req[m_owner] && !bus.stop) eg[m_owner] = 1'b1;
        if (rq.size() > 0 && rq[0].due == cnum) begin
            ev[rq[0].own] = 1'b1;
            e_rdata = rq[0].data;
            void'(rq.pop_front());
        end
        chk("gnt", bus.gnt, eg);
        chk("rvalid", bus.rvalid, ev);
        chk("rdata", bus.rdata, e_rdata);
        chk("ram_cs_n", bus.ram_cs_n, e_cs_n);
        chk("ram_wr", bus.ram_wr, e_wr);
        chk("ram_addr", bus.ram_addr, e_addr);
        chk("ram_din", bus.ram_din, e_din);
        chk("owner", bus.owner, m_owner);
        chk("busy", bus.busy, m_burst || rq.size() > 0);
    endtask

    task automatic model_step();
        bit acc;
        acc = m_burst && bus.req[m_owner] && !bus.stop;
        e_cs_n = !acc;
        e_wr = 0;
        if (acc) begin
            e_wr   = bus.wr[m_owner];
            e_addr = bus.addr[m_owner*AW +: AW];
            e_din  = bus.wdata[m_owner*DW +: DW];
            if (e_wr) shadow[e_addr] = e_din;
            else rq.push_back('{cnum + 2 + RL, m_owner, shadow[e_addr]});
            m_beats++;
        end
        if (!m_burst) begin
            if (bus.req != 0 && !bus.stop) begin
                m_owner = pick(bus.req);
                m_burst = 1;
            end
        end else if ((acc && m_beats == BL) || (!bus.req[m_owner] && !bus.stop)) begin
            m_last = m_owner; m_owner = 3; m_beats = 0; m_burst = 0;
        end
        cnum++;
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req = r; bus.wr = w; bus.addr = {3{a}}; bus.wdata = {3{d}};
    endtask

    task automatic do_reset();
        reset_n = 0;
        drive(3'b000, 3'b000, '0, '0);
        bus.stop = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all();
        reset_n = 1;
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin ram[i] = '0; shadow[i] = '0; end
        ram[14'h20] = 32'h12345678;
        shadow[14'h20] = 32'h12345678;
        bus.ram_dout = '0;
        do_reset();

        drive(3'b111, 3'b111, 14'h100, 32'hA5A5_0000);
        for (int c = 0; c < 20; c++) begin
            if (c % 5 == 2) chk("rr_owner", bus.owner, exp_own[c / 5]);
            cyc();
        end
        do_reset();

        drive(3'b001, 3'b001, 14'h0010, 32'hDEADBEEF);
        repeat (5) cyc();
        drive(3'b000, 3'b000, '0, '0);
        repeat (2) cyc();

        drive(3'b010, 3'b000, 14'h0020, '0);
        repeat (2) cyc();
        drive(3'b000, 3'b000, '0, '0);
        repeat (2) cyc();
        chk("rd_lat_rvalid", bus.rvalid, 3'b010);
        chk("rd_lat_rdata", bus.rdata, 32'h12345678);
        repeat (2) cyc();

        drive(3'b010, 3'b000, 14'h0020, '0);
        repeat (3) cyc();
        bus.stop = 1;
        repeat (3) cyc();
        bus.stop = 0;
        repeat (2) cyc();
        drive(3'b000, 3'b000, '0, '0);
        repeat (4) cyc();

        drive(3'b110, 3'b000, 14'h0020, '0);
        repeat (2) cyc();
        bus.req = 3'b010;
        repeat (6) cyc();
        drive(3'b000, 3'b000, '0, '0);
        repeat (4) cyc();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 3'($urandom_range(0, 7));
            bus.wr = 3'($urandom_range(0, 7));
            bus.stop = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 3; i++) begin
                bus.addr[i*AW +: AW] = AW'($urandom_range(0, 15));
                bus.wdata[i*DW +: DW] = $urandom;
            end
            cyc();
        end
        bus.stop = 0;
        drive(3'b000, 3'b000, '0, '0);
        repeat (8) cyc();

        drive(3'b010, 3'b000, 14'h0003, '0);
        repeat (3) cyc();
        reset_n = 0;
        #1;
        model_reset();
        check_all();
        drive(3'b000, 3'b000, '0, '0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1;
        repeat (6) cyc();
        chk("post_reset_busy", bus.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
